// File: rtl/lc_arbiter.sv
// ---------------------------------------------------------------------------
// lc_arbiter
//   Merges the line-granular lower-cache request ports of N_CH first-level
//   caches (default: L1I on channel 0, L1D on channel 1) into a single port
//   toward the next memory level.
//
//   Requests are granted round-robin and registered into a one-entry output
//   stage. Reads push the issuing channel index into an ID FIFO; responses
//   return strictly in order and are routed to the channel at the FIFO head.
//   Writes (dirty-line evictions) are posted and produce no response.
//
// Ports
//   clk_in, rst_N_in        clock, asynchronous active-low reset
//   cs_N_in                 chip select (active-low); high blocks new grants
//   req_*                   per-channel request ports (addr/value packed
//                           channel i at [i*W +: W]); req_ready_out is the
//                           combinational one-hot grant
//   resp_*                  per-channel read-response ports; addr/value are
//                           broadcast pass-through of the downstream response
//   mem_*_out / mem_ready_in   downstream request (registered output stage)
//   mem_*_in  / mem_ready_out  downstream response
//   outstanding_out         ID FIFO occupancy (reads in flight)
//   err_out                 sticky: response arrived with no read outstanding
// ---------------------------------------------------------------------------
module lc_arbiter #(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned LINE_W  = 512,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_N_in,
  input  logic                         cs_N_in,

  input  logic [N_CH-1:0]              req_valid_in,
  output logic [N_CH-1:0]              req_ready_out,
  input  logic [N_CH*ADDR_W-1:0]       req_addr_in,
  input  logic [N_CH*LINE_W-1:0]       req_value_in,
  input  logic [N_CH-1:0]              req_we_in,

  output logic [N_CH-1:0]              resp_valid_out,
  input  logic [N_CH-1:0]              resp_ready_in,
  output logic [ADDR_W-1:0]            resp_addr_out,
  output logic [LINE_W-1:0]            resp_value_out,

  output logic                         mem_valid_out,
  input  logic                         mem_ready_in,
  output logic [ADDR_W-1:0]            mem_addr_out,
  output logic [LINE_W-1:0]            mem_value_out,
  output logic                         mem_we_out,

  input  logic                         mem_valid_in,
  output logic                         mem_ready_out,
  input  logic [ADDR_W-1:0]            mem_addr_in,
  input  logic [LINE_W-1:0]            mem_value_in,

  output logic [$clog2(MAX_OUT+1)-1:0] outstanding_out,
  output logic                         err_out
);

  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  // Arbitration state
  logic [CH_W-1:0]   r_last_grant;

  // One-entry output stage
  logic              r_stage_valid;
  logic [ADDR_W-1:0] r_stage_addr;
  logic [LINE_W-1:0] r_stage_value;
  logic              r_stage_we;

  // Read ID FIFO
  logic [CH_W-1:0]   r_fifo [MAX_OUT];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              r_err;

  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [CH_W-1:0]   w_head;
  logic [N_CH-1:0]   w_eligible;
  logic              w_stage_free;
  logic              w_grant_en;
  logic              w_grant_hit;
  logic [CH_W-1:0]   w_grant_idx;
  logic              w_accept;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [LINE_W-1:0] w_sel_value;
  logic              w_sel_we;
  logic              w_push;
  logic              w_pop;

  // Pointer increment with explicit wrap at MAX_OUT
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == CNT_W'(MAX_OUT));
  assign w_head       = r_fifo[r_rd_ptr];

  // Reads need a free ID slot (count before any same-cycle pop); writes never do
  always_comb begin : eligibility
    w_eligible = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_eligible[i] = req_valid_in[i] & (req_we_in[i] | ~w_fifo_full);
    end
  end

  assign w_stage_free = ~r_stage_valid | mem_ready_in;
  assign w_grant_en   = rst_N_in & ~cs_N_in & w_stage_free;

  // Round-robin pick: the eligible channel closest after r_last_grant wins
  always_comb begin : rr_pick
    int unsigned v_best;
    int unsigned v_dist;
    w_grant_hit = 1'b0;
    w_grant_idx = '0;
    v_best      = N_CH;
    v_dist      = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      v_dist = (i + N_CH - 32'(r_last_grant) - 1) % N_CH;
      if (w_eligible[i] && (v_dist < v_best)) begin
        v_best      = v_dist;
        w_grant_hit = 1'b1;
        w_grant_idx = CH_W'(i);
      end
    end
  end

  // One-hot grant and mux of the granted channel's payload
  always_comb begin : grant_mux
    req_ready_out = '0;
    w_sel_addr    = '0;
    w_sel_value   = '0;
    w_sel_we      = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_grant_idx == CH_W'(i)) begin
        req_ready_out[i] = w_grant_en & w_grant_hit;
        w_sel_addr       = req_addr_in[i*ADDR_W +: ADDR_W];
        w_sel_value      = req_value_in[i*LINE_W +: LINE_W];
        w_sel_we         = req_we_in[i];
      end
    end
  end

  assign w_accept = |(req_ready_out & req_valid_in);
  assign w_push   = w_accept & ~w_sel_we;

  // Response routing to the channel named by the FIFO head
  always_comb begin : resp_route
    resp_valid_out = '0;
    mem_ready_out  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_head == CH_W'(i)) begin
        resp_valid_out[i] = mem_valid_in & ~w_fifo_empty;
        mem_ready_out     = ~w_fifo_empty & resp_ready_in[i];
      end
    end
  end

  assign w_pop = mem_valid_in & mem_ready_out;

  // Broadcast response payload; forced to zero while reset is held
  assign resp_addr_out  = rst_N_in ? mem_addr_in  : '0;
  assign resp_value_out = rst_N_in ? mem_value_in : '0;

  // Output stage: reload on accept, otherwise clear on downstream handshake
  always_ff @(posedge clk_in or negedge rst_N_in) begin : stage_reg
    if (!rst_N_in) begin
      r_stage_valid <= 1'b0;
      r_stage_addr  <= '0;
      r_stage_value <= '0;
      r_stage_we    <= 1'b0;
      r_last_grant  <= CH_W'(N_CH - 1);
    end else if (w_accept) begin
      r_stage_valid <= 1'b1;
      r_stage_addr  <= w_sel_addr;
      r_stage_value <= w_sel_value;
      r_stage_we    <= w_sel_we;
      r_last_grant  <= w_grant_idx;
    end else if (r_stage_valid && mem_ready_in) begin
      r_stage_valid <= 1'b0;
    end
  end

  // ID FIFO; push is never issued when full, so a push+pop keeps count
  always_ff @(posedge clk_in or negedge rst_N_in) begin : id_fifo
    if (!rst_N_in) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        r_fifo[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_grant_idx;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error: a response with nothing outstanding
  always_ff @(posedge clk_in or negedge rst_N_in) begin : err_reg
    if (!rst_N_in) begin
      r_err <= 1'b0;
    end else if (mem_valid_in && w_fifo_empty) begin
      r_err <= 1'b1;
    end
  end

  assign mem_valid_out   = r_stage_valid;
  assign mem_addr_out    = r_stage_addr;
  assign mem_value_out   = r_stage_value;
  assign mem_we_out      = r_stage_we;
  assign outstanding_out = r_count;
  assign err_out         = r_err;

endmodule

// File: tb/tb_lc_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lc_arbiter
//   Directed scenarios followed by randomized traffic, all checked against a
//   queue-based reference model of the arbiter kept in this file.
// ---------------------------------------------------------------------------
module tb_lc_arbiter;

  localparam int unsigned N_CH    = 2;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned LINE_W  = 512;
  localparam int unsigned MAX_OUT = 4;
  localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1);

  logic                   clk_in;
  logic                   rst_N_in;
  logic                   cs_N_in;
  logic [N_CH-1:0]        req_valid_in;
  logic [N_CH-1:0]        req_ready_out;
  logic [N_CH*ADDR_W-1:0] req_addr_in;
  logic [N_CH*LINE_W-1:0] req_value_in;
  logic [N_CH-1:0]        req_we_in;
  logic [N_CH-1:0]        resp_valid_out;
  logic [N_CH-1:0]        resp_ready_in;
  logic [ADDR_W-1:0]      resp_addr_out;
  logic [LINE_W-1:0]      resp_value_out;
  logic                   mem_valid_out;
  logic                   mem_ready_in;
  logic [ADDR_W-1:0]      mem_addr_out;
  logic [LINE_W-1:0]      mem_value_out;
  logic                   mem_we_out;
  logic                   mem_valid_in;
  logic                   mem_ready_out;
  logic [ADDR_W-1:0]      mem_addr_in;
  logic [LINE_W-1:0]      mem_value_in;
  logic [CNT_W-1:0]       outstanding_out;
  logic                   err_out;

  lc_arbiter #(
    .N_CH(N_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in), .cs_N_in(cs_N_in),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_addr_in(req_addr_in), .req_value_in(req_value_in), .req_we_in(req_we_in),
    .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
    .resp_addr_out(resp_addr_out), .resp_value_out(resp_value_out),
    .mem_valid_out(mem_valid_out), .mem_ready_in(mem_ready_in),
    .mem_addr_out(mem_addr_out), .mem_value_out(mem_value_out), .mem_we_out(mem_we_out),
    .mem_valid_in(mem_valid_in), .mem_ready_out(mem_ready_out),
    .mem_addr_in(mem_addr_in), .mem_value_in(mem_value_in),
    .outstanding_out(outstanding_out), .err_out(err_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks;
  int n_errors;

  // Reference model state
  int                m_last;
  int                m_q[$];
  bit                m_sv;
  logic [ADDR_W-1:0] m_sa;
  logic [LINE_W-1:0] m_sd;
  bit                m_swe;
  bit                m_err;
  int                dut_grants[$];

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                          input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    v = '0;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int model_grant();
    int c;
    if (!rst_N_in || cs_N_in || (m_sv && !mem_ready_in)) return -1;
    for (int k = 1; k <= N_CH; k++) begin
      c = (m_last + k) % N_CH;
      if (req_valid_in[c] && (req_we_in[c] || m_q.size() < MAX_OUT)) return c;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_last = N_CH - 1;
    m_q.delete();
    m_sv   = 1'b0;
    m_swe  = 1'b0;
    m_sa   = '0;
    m_sd   = '0;
    m_err  = 1'b0;
  endfunction

  // Compare all outputs against the model, then advance one clock
  task automatic step();
    logic [N_CH-1:0] exp_rdy;
    logic [N_CH-1:0] exp_rv;
    logic            exp_mr;
    int              g;
    #1;
    g       = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_rv = '0;
    exp_mr = 1'b0;
    if (m_q.size() > 0) begin
      exp_rv[m_q[0]] = mem_valid_in;
      exp_mr         = resp_ready_in[m_q[0]];
    end
    for (int c = 0; c < N_CH; c++) if (req_ready_out[c]) dut_grants.push_back(c);
    check_eq("req_ready", LINE_W'(req_ready_out), LINE_W'(exp_rdy));
    check_eq("resp_valid", LINE_W'(resp_valid_out), LINE_W'(exp_rv));
    check_eq("mem_ready_out", LINE_W'(mem_ready_out), LINE_W'(exp_mr));
    check_eq("resp_addr", LINE_W'(resp_addr_out), LINE_W'(mem_addr_in));
    check_eq("resp_value", resp_value_out, mem_value_in);
    check_eq("mem_valid", LINE_W'(mem_valid_out), LINE_W'(m_sv));
    if (m_sv) begin
      check_eq("mem_addr", LINE_W'(mem_addr_out), LINE_W'(m_sa));
      check_eq("mem_value", mem_value_out, m_sd);
      check_eq("mem_we", LINE_W'(mem_we_out), LINE_W'(m_swe));
    end
    check_eq("outstanding", LINE_W'(outstanding_out), LINE_W'(m_q.size()));
    check_eq("err", LINE_W'(err_out), LINE_W'(m_err));
    // next state
    if (mem_valid_in && m_q.size() == 0) m_err = 1'b1;
    if (mem_valid_in && exp_mr) void'(m_q.pop_front());
    if (g >= 0) begin
      m_sv   = 1'b1;
      m_sa   = req_addr_in[g*ADDR_W +: ADDR_W];
      m_sd   = req_value_in[g*LINE_W +: LINE_W];
      m_swe  = req_we_in[g];
      m_last = g;
      if (!req_we_in[g]) m_q.push_back(g);
    end else if (m_sv && mem_ready_in) begin
      m_sv = 1'b0;
    end
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  // Asserts reset now, checks outputs are zero immediately, releases at a negedge
  task automatic apply_reset(input int hold);
    rst_N_in = 1'b0;
    #1;
    check_eq("rst_req_ready", LINE_W'(req_ready_out), '0);
    check_eq("rst_resp_valid", LINE_W'(resp_valid_out), '0);
    check_eq("rst_resp_addr", LINE_W'(resp_addr_out), '0);
    check_eq("rst_resp_value", resp_value_out, '0);
    check_eq("rst_mem_valid", LINE_W'(mem_valid_out), '0);
    check_eq("rst_mem_addr", LINE_W'(mem_addr_out), '0);
    check_eq("rst_mem_value", mem_value_out, '0);
    check_eq("rst_mem_we", LINE_W'(mem_we_out), '0);
    check_eq("rst_mem_ready_out", LINE_W'(mem_ready_out), '0);
    check_eq("rst_outstanding", LINE_W'(outstanding_out), '0);
    check_eq("rst_err", LINE_W'(err_out), '0);
    model_reset();
    repeat (hold) @(negedge clk_in);
    rst_N_in = 1'b1;
  endtask

  task automatic set_idle();
    cs_N_in       = 1'b0;
    req_valid_in  = '0;
    req_we_in     = '0;
    resp_ready_in = '0;
    mem_ready_in  = 1'b1;
    mem_valid_in  = 1'b0;
  endtask

  task automatic set_req(input int ch, input bit we, input logic [ADDR_W-1:0] addr);
    req_valid_in[ch]                  = 1'b1;
    req_we_in[ch]                     = we;
    req_addr_in[ch*ADDR_W +: ADDR_W]  = addr;
    req_value_in[ch*LINE_W +: LINE_W] = rand_line();
  endtask

  // Return responses until the model has nothing outstanding and the stage is empty
  task automatic drain();
    set_idle();
    resp_ready_in = '1;
    for (int n = 0; n < 16 && (m_q.size() > 0 || m_sv); n++) begin
      mem_valid_in = (m_q.size() > 0);
      mem_addr_in  = {$urandom, $urandom};
      mem_value_in = rand_line();
      step();
    end
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] line_a;
    n_checks     = 0;
    n_errors     = 0;
    rst_N_in     = 1'b0;
    req_addr_in  = '0;
    req_value_in = '0;
    mem_addr_in  = '0;
    mem_value_in = '0;
    set_idle();
    model_reset();
    apply_reset(2);

    // Alternating grants between two reading channels
    dut_grants.delete();
    set_req(0, 1'b0, 64'h100);
    set_req(1, 1'b0, 64'h200);
    repeat (4) step();
    check_eq("alt_count", LINE_W'(dut_grants.size()), LINE_W'(4));
    for (int i = 0; i < 4 && i < dut_grants.size(); i++)
      check_eq("alt_grant", LINE_W'(dut_grants[i]), LINE_W'(i % 2));
    drain();

    // In-order response routing: ch1 then ch0
    set_req(1, 1'b0, 64'h40);
    step();
    set_idle();
    set_req(0, 1'b0, 64'h80);
    step();
    set_idle();
    step();
    check_eq("route_outstanding", LINE_W'(outstanding_out), LINE_W'(2));
    resp_ready_in = '1;
    mem_valid_in  = 1'b1;
    line_a        = rand_line();
    mem_value_in  = line_a;
    mem_addr_in   = 64'h40;
    #1;
    check_eq("route_first", LINE_W'(resp_valid_out), LINE_W'(2'b10));
    step();
    mem_value_in = ~line_a;
    mem_addr_in  = 64'h80;
    #1;
    check_eq("route_second", LINE_W'(resp_valid_out), LINE_W'(2'b01));
    step();
    set_idle();
    step();
    check_eq("route_done", LINE_W'(outstanding_out), LINE_W'(0));

    // Read limit: four reads fill the FIFO, a fifth waits, a write passes
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b0, ADDR_W'(64'h1000 + i * 64));
      step();
    end
    set_req(0, 1'b0, 64'h2000);
    #1;
    check_eq("limit_blocked", LINE_W'(req_ready_out), '0);
    step();
    set_req(0, 1'b1, 64'h3000);
    set_req(1, 1'b0, 64'h3100);
    #1;
    check_eq("limit_write_grant", LINE_W'(req_ready_out), LINE_W'(2'b01));
    step();
    req_valid_in[0] = 1'b0;
    #1;
    check_eq("limit_write_we", LINE_W'(mem_we_out), LINE_W'(1));
    resp_ready_in = '1;
    mem_valid_in  = 1'b1;
    step();
    mem_valid_in = 1'b0;
    #1;
    check_eq("limit_read_grant", LINE_W'(req_ready_out), LINE_W'(2'b10));
    step();
    drain();

    // Backpressure: stage held for five cycles, then drain and grant together
    set_req(0, 1'b0, 64'h300);
    step();
    set_idle();
    mem_ready_in = 1'b0;
    set_req(1, 1'b0, 64'h400);
    repeat (5) begin
      #1;
      check_eq("bp_ready", LINE_W'(req_ready_out), '0);
      check_eq("bp_hold_addr", LINE_W'(mem_addr_out), LINE_W'(64'h300));
      step();
    end
    mem_ready_in = 1'b1;
    #1;
    check_eq("bp_release_grant", LINE_W'(req_ready_out), LINE_W'(2'b10));
    step();
    drain();

    // Chip select blocks grants; response on empty FIFO sets err
    cs_N_in = 1'b1;
    set_req(0, 1'b0, 64'h500);
    set_req(1, 1'b1, 64'h600);
    repeat (3) step();
    set_idle();
    mem_valid_in  = 1'b1;
    resp_ready_in = '1;
    #1;
    check_eq("empty_resp_ready", LINE_W'(mem_ready_out), '0);
    step();
    set_idle();
    repeat (3) step();
    check_eq("err_sticky", LINE_W'(err_out), LINE_W'(1));
    apply_reset(1);
    step();

    // Reset mid-flight with two reads outstanding and the stage loaded
    set_req(0, 1'b0, 64'h700);
    step();
    set_idle();
    set_req(1, 1'b0, 64'h800);
    step();
    set_idle();
    mem_ready_in = 1'b0;
    step();
    check_eq("mid_valid", LINE_W'(mem_valid_out), LINE_W'(1));
    check_eq("mid_outstanding", LINE_W'(outstanding_out), LINE_W'(2));
    set_req(0, 1'b0, 64'h900);
    set_req(1, 1'b0, 64'hA00);
    mem_addr_in = 64'hDEAD;
    #2;
    apply_reset(1);
    mem_ready_in = 1'b1;
    #1;
    check_eq("post_rst_grant", LINE_W'(req_ready_out), LINE_W'(2'b01));
    step();
    drain();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(499) == 0) begin
        apply_reset(1);
      end
      cs_N_in      = ($urandom_range(7) == 0);
      mem_ready_in = ($urandom_range(3) != 0);
      for (int c = 0; c < N_CH; c++) begin
        req_valid_in[c]                  = ($urandom_range(1) == 1);
        req_we_in[c]                     = ($urandom_range(2) == 0);
        req_addr_in[c*ADDR_W +: ADDR_W]  = {$urandom, $urandom};
        req_value_in[c*LINE_W +: LINE_W] = rand_line();
      end
      resp_ready_in = N_CH'($urandom);
      if (m_q.size() > 0) mem_valid_in = ($urandom_range(1) == 1);
      else                mem_valid_in = ($urandom_range(49) == 0);
      mem_addr_in  = {$urandom, $urandom};
      mem_value_in = rand_line();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
